step_sequencer: RTL and testbench

- Sequences the microcode step counter and holds the architectural state that drives the combinational control-word decoder: the instruction register, the step index and the latched ALU flags.
- Generates the datapath clock-enable, which supports free-run and single-step (debug) modes.
- Implements halt, and a step-overrun fault trap for microcode sequences that never issue ADV.
- Sits between the bus/ALU and the decoder. Decoder control bits II, ADV, HLT and EL are fed back in as inputs.

---
 rtl/step_sequencer.sv | 92 +++++++++
 tb/tb_step_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Microcode step sequencer: instruction register, step counter, latched ALU flags,
// datapath clock-enable (free-run / single-step) and halt / overrun-fault trapping.
module step_sequencer #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned INSTRUCTION_STEPS = 32,
  localparam int unsigned STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_run_mode,
  input  logic                         i_step_btn,
  input  logic [INSTRUCTION_WIDTH-1:0] i_bus,
  input  logic                         i_ii,
  input  logic                         i_adv,
  input  logic                         i_hlt,
  input  logic                         i_el,
  input  logic                         i_alu_zero,
  input  logic                         i_alu_carry,
  input  logic                         i_alu_odd,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [STEP_WIDTH-1:0]        o_step,
  output logic                         o_zero,
  output logic                         o_carry,
  output logic                         o_odd,
  output logic                         o_clk_en,
  output logic                         o_halted,
  output logic                         o_fault
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(INSTRUCTION_STEPS - 1);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

  state_t                state, state_next;
  logic [STEP_WIDTH-1:0] step_next;
  logic                  btn_q;
  logic                  btn_rise;

  assign btn_rise = i_step_btn & ~btn_q;

  // State register; btn_q is the only register that updates without o_clk_en.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= RUN;
      o_step        <= '0;
      o_instruction <= '0;
      o_zero        <= 1'b0;
      o_carry       <= 1'b0;
      o_odd         <= 1'b0;
      btn_q         <= 1'b0;
    end else begin
      btn_q  <= i_step_btn;
      state  <= state_next;
      o_step <= step_next;
      if (o_clk_en && i_ii) o_instruction <= i_bus;
      if (o_clk_en && i_el) begin
        o_zero  <= i_alu_zero;
        o_carry <= i_alu_carry;
        o_odd   <= i_alu_odd;
      end
    end
  end

  // Next-state / next-step: HLT beats ADV beats the overrun trap.
  always_comb begin
    state_next = state;
    step_next  = o_step;
    if (o_clk_en) begin
      if (i_hlt) begin
        state_next = HALTED;
      end else if (i_adv) begin
        step_next = '0;
      end else if (o_step == STEP_LAST) begin
        state_next = FAULT;
      end else begin
        step_next = o_step + STEP_ONE;
      end
    end
  end

  always_comb begin
    o_clk_en = (state == RUN) & (i_run_mode | btn_rise);
    o_halted = (state == HALTED);
    o_fault  = (state == FAULT);
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: expectations queued at stimulus time and
// popped/asserted once the DUT output is due.
module tb_step_sequencer;

  localparam int unsigned IW    = 16;
  localparam int unsigned STEPS = 32;
  localparam int unsigned SW    = $clog2(STEPS);

  logic          clk = 1'b0;
  logic          reset, run_mode, step_btn, ii, adv, hlt, el;
  logic          alu_zero, alu_carry, alu_odd;
  logic [IW-1:0] bus;
  logic [IW-1:0] instruction;
  logic [SW-1:0] step;
  logic          zero, carry, odd, clk_en, halted, fault;

  step_sequencer #(
    .INSTRUCTION_WIDTH(IW),
    .INSTRUCTION_STEPS(STEPS)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_run_mode(run_mode),
    .i_step_btn(step_btn),
    .i_bus(bus),
    .i_ii(ii),
    .i_adv(adv),
    .i_hlt(hlt),
    .i_el(el),
    .i_alu_zero(alu_zero),
    .i_alu_carry(alu_carry),
    .i_alu_odd(alu_odd),
    .o_instruction(instruction),
    .o_step(step),
    .o_zero(zero),
    .o_carry(carry),
    .o_odd(odd),
    .o_clk_en(clk_en),
    .o_halted(halted),
    .o_fault(fault)
  );

  always #5 clk = ~clk;

  typedef enum int unsigned { SIG_STEP, SIG_INSTR, SIG_FLAGS, SIG_CLKEN, SIG_HALT, SIG_FAULT } sig_t;
  typedef struct {
    string       tag;
    sig_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t queue_exp[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(sig_t sel);
    case (sel)
      SIG_STEP:  return 32'(step);
      SIG_INSTR: return 32'(instruction);
      SIG_FLAGS: return 32'({zero, carry, odd});
      SIG_CLKEN: return 32'(clk_en);
      SIG_HALT:  return 32'(halted);
      default:   return 32'(fault);
    endcase
  endfunction

  task automatic push(input string tag, input sig_t sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    queue_exp.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (queue_exp.size() > 0) begin
      e   = queue_exp.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // clk_en is combinational on current inputs: let them settle, then check.
  task automatic check_en(input string tag, input logic exp);
    #1;
    push(tag, SIG_CLKEN, 32'(exp));
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle_outputs(input string tag);
    push({tag, "_step"},  SIG_STEP,  0);
    push({tag, "_instr"}, SIG_INSTR, 0);
    push({tag, "_flags"}, SIG_FLAGS, 0);
    push({tag, "_halt"},  SIG_HALT,  0);
    push({tag, "_fault"}, SIG_FAULT, 0);
  endtask

  initial begin
    reset = 1'b1; run_mode = 1'b1; step_btn = 1'b0; bus = '0;
    ii = 1'b0; adv = 1'b0; hlt = 1'b0; el = 1'b0;
    alu_zero = 1'b0; alu_carry = 1'b0; alu_odd = 1'b0;
    tick(); tick();
    expect_idle_outputs("reset");
    drain();
    reset = 1'b0;

    // Free-run fetch / advance: 0,1,2,3,0
    check_en("fr_en0", 1'b1);
    tick(); push("fr_step1", SIG_STEP, 1); drain();
    ii = 1'b1; bus = 16'h002a;
    check_en("fr_en1", 1'b1);
    tick(); ii = 1'b0; bus = '0;
    push("fr_step2", SIG_STEP, 2); push("fr_instr2", SIG_INSTR, 32'h002a); drain();
    check_en("fr_en2", 1'b1);
    tick(); push("fr_step3", SIG_STEP, 3); push("fr_instr3", SIG_INSTR, 32'h002a); drain();
    adv = 1'b1;
    check_en("fr_en3", 1'b1);
    tick(); adv = 1'b0;
    push("fr_wrap", SIG_STEP, 0); push("fr_instr_wrap", SIG_INSTR, 32'h002a); drain();

    // Single-step: one enabled cycle per rising edge of the button
    run_mode = 1'b0;
    check_en("ss_idle_en", 1'b0);
    step_btn = 1'b1;
    check_en("ss_press1_en", 1'b1);
    tick(); push("ss_step1", SIG_STEP, 1); drain();
    for (int i = 0; i < 4; i++) begin
      check_en("ss_held_en", 1'b0);
      tick(); push("ss_held_step", SIG_STEP, 1); drain();
    end
    step_btn = 1'b0;
    check_en("ss_release_en", 1'b0);
    tick(); push("ss_release_step", SIG_STEP, 1); drain();
    step_btn = 1'b1;
    check_en("ss_press2_en", 1'b1);
    tick(); push("ss_step2", SIG_STEP, 2); drain();
    step_btn = 1'b0;
    tick(); push("ss_after_step", SIG_STEP, 2); drain();

    // Flag latch, then hold with EL low, then hold with clk_en low
    run_mode = 1'b1; el = 1'b1; alu_zero = 1'b1; alu_carry = 1'b1; alu_odd = 1'b0;
    tick(); push("fl_latch", SIG_FLAGS, 3'b110); push("fl_step", SIG_STEP, 3); drain();
    el = 1'b0; alu_zero = 1'b0;
    tick(); push("fl_hold_el0", SIG_FLAGS, 3'b110); drain();
    run_mode = 1'b0; el = 1'b1; alu_carry = 1'b0; alu_odd = 1'b1;
    check_en("fl_noen", 1'b0);
    tick(); push("fl_hold_noen", SIG_FLAGS, 3'b110); push("fl_hold_step", SIG_STEP, 4); drain();
    el = 1'b0; alu_odd = 1'b0;

    // Reset mid-instruction with ADV and EL asserted
    reset = 1'b1; tick(); reset = 1'b0; run_mode = 1'b1;
    ii = 1'b1; bus = 16'hbeef; el = 1'b1; alu_zero = 1'b1;
    tick(); ii = 1'b0; bus = '0; el = 1'b0; alu_zero = 1'b0;
    push("rm_pre_instr", SIG_INSTR, 32'hbeef); push("rm_pre_flags", SIG_FLAGS, 3'b100); drain();
    tick(); tick();
    push("rm_pre_step", SIG_STEP, 3); drain();
    reset = 1'b1; adv = 1'b1; el = 1'b1; alu_carry = 1'b1;
    tick(); reset = 1'b0; adv = 1'b0; el = 1'b0; alu_carry = 1'b0;
    expect_idle_outputs("rm");
    drain();

    // Halt at step 2 together with II
    tick(); tick();
    push("h_pre_step", SIG_STEP, 2); drain();
    hlt = 1'b1; ii = 1'b1; bus = 16'h1234;
    check_en("h_en", 1'b1);
    tick(); hlt = 1'b0; ii = 1'b0; bus = '0;
    push("h_halted", SIG_HALT, 1); push("h_step", SIG_STEP, 2);
    push("h_instr", SIG_INSTR, 32'h1234); drain();
    check_en("h_en_run", 1'b0);
    tick(); push("h_step_hold", SIG_STEP, 2); drain();
    run_mode = 1'b0; step_btn = 1'b0;
    tick();
    step_btn = 1'b1;
    check_en("h_en_btn", 1'b0);
    tick(); step_btn = 1'b0;
    push("h_step_btn", SIG_STEP, 2); push("h_still", SIG_HALT, 1); drain();
    reset = 1'b1; tick(); reset = 1'b0; run_mode = 1'b1;
    expect_idle_outputs("h_reset");
    drain();

    // Overrun: run to the last step with no ADV
    for (int i = 1; i < STEPS; i++) begin
      tick();
      push("ov_count", SIG_STEP, 32'(i));
      drain();
    end
    check_en("ov_en_last", 1'b1);
    tick();
    push("ov_fault", SIG_FAULT, 1); push("ov_step", SIG_STEP, STEPS - 1); drain();
    check_en("ov_en_fault", 1'b0);
    tick(); push("ov_step_hold", SIG_STEP, STEPS - 1); push("ov_fault_hold", SIG_FAULT, 1); drain();

    // ADV on the final step wraps without fault
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i < STEPS; i++) tick();
    push("adv_last_pre", SIG_STEP, STEPS - 1); drain();
    adv = 1'b1;
    tick(); adv = 1'b0;
    push("adv_last_step", SIG_STEP, 0); push("adv_last_fault", SIG_FAULT, 0); drain();
    check_en("adv_last_en", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
